// File: rtl/fixed_pkg.sv
// Shared 17-bit sign-magnitude fixed-point definitions (Q8.8 magnitude, sign in bit 16).
package fixed_pkg;
   localparam int FX_W    = 17;
   localparam int FX_FRAC = 8;
   localparam int FX_SIGN = 16;

   localparam logic [FX_W-1:0] FX_ZERO = 17'h00000;
   localparam logic [FX_W-1:0] FX_ONE  = 17'h00100;

   function automatic logic [FX_W-1:0] fx_neg(input logic [FX_W-1:0] x);
      logic [FX_W-1:0] r;
      r = x;
      r[FX_SIGN] = ~x[FX_SIGN];
      return r;
   endfunction
endpackage

// File: rtl/fixed_adder.sv
// Sign-magnitude fixed-point adder/subtractor with a registered, unreset result; magnitude saturates.
module fixed_adder
   import fixed_pkg::*;
(
   input  logic            clk,
   input  logic [FX_W-1:0] a,
   input  logic [FX_W-1:0] b,
   input  logic            sub,
   output logic [FX_W-1:0] sum
);
   logic [FX_W-1:0]    b_eff;
   logic [FX_SIGN-1:0] mag_a;
   logic [FX_SIGN-1:0] mag_b;
   logic [FX_SIGN:0]   mag_wide;
   logic [FX_SIGN-1:0] mag_res;
   logic               sign_res;
   logic [FX_W-1:0]    sum_next;
   logic [FX_W-1:0]    sum_reg;

   always_comb begin
      b_eff    = sub ? fx_neg(b) : b;
      mag_a    = a[FX_SIGN-1:0];
      mag_b    = b_eff[FX_SIGN-1:0];
      mag_wide = {1'b0, mag_a} + {1'b0, mag_b};
      mag_res  = '0;
      sign_res = 1'b0;
      if (a[FX_SIGN] == b_eff[FX_SIGN]) begin
         mag_res  = mag_wide[FX_SIGN] ? '1 : mag_wide[FX_SIGN-1:0];
         sign_res = a[FX_SIGN];
      end else if (mag_a >= mag_b) begin
         mag_res  = mag_a - mag_b;
         sign_res = a[FX_SIGN];
      end else begin
         mag_res  = mag_b - mag_a;
         sign_res = b_eff[FX_SIGN];
      end
      // Canonical zero is positive so equal-magnitude cancellations compare cleanly.
      if (mag_res == '0) begin
         sign_res = 1'b0;
      end
      sum_next = {sign_res, mag_res};
   end

   always_ff @(posedge clk) begin
      sum_reg <= sum_next;
   end

   assign sum = sum_reg;
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational search from ptr_reg, pointer advances past each winner.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  win,
   output logic             any_grant
);
   logic [ID_W-1:0] ptr_reg;
   logic [ID_W-1:0] ptr_next;
   logic [ID_W:0]   cand_sum [N_REQ];
   logic [ID_W-1:0] cand_idx [N_REQ];
   logic            found;
   logic [ID_W-1:0] win_next;

   // Candidate index for each search offset, wrapped modulo N_REQ (N_REQ need not be a power of two).
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, ptr_reg} + (ID_W+1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= (ID_W+1)'(N_REQ))
                          ? ID_W'(cand_sum[gi] - (ID_W+1)'(N_REQ))
                          : cand_sum[gi][ID_W-1:0];
   end

   // Walk offsets from farthest to nearest so the nearest set request is the last assignment.
   always_comb begin
      found    = 1'b0;
      win_next = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[cand_idx[k]]) begin
            found    = 1'b1;
            win_next = cand_idx[k];
         end
      end
   end

   assign win       = win_next;
   assign any_grant = found & en & rst_n;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign grant[gi] = any_grant && (win_next == ID_W'(gi));
   end

   assign ptr_next = (win_next == ID_W'(N_REQ - 1)) ? '0 : win_next + ID_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else if (any_grant) begin
         ptr_reg <= ptr_next;
      end
   end
endmodule

// File: rtl/fadd_share_arbiter.sv
// Round-robin sharing of one fixed_adder among N_REQ requesters, 1-cycle result latency.
// Optional statistics counters are built when FADD_ARB_STATS_EN is defined.
module fadd_share_arbiter
   import fixed_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = FX_W,
   parameter int ID_W  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   input  logic [N_REQ-1:0]   req_sub,
   output logic [N_REQ-1:0]   resp_valid,
   output logic [W-1:0]       resp_sum,
   output logic [ID_W-1:0]    resp_id
`ifdef FADD_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0] stat_grant_cnt,
   output logic [15:0]         stat_stall_cnt
`endif
);
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  win;
   logic             any_grant;
   logic [W-1:0]     add_a;
   logic [W-1:0]     add_b;
   logic             add_sub;
   logic [W-1:0]     add_sum;
   logic [N_REQ-1:0] resp_valid_reg;
   logic [ID_W-1:0]  resp_id_reg;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req_valid),
      .grant     (grant),
      .win       (win),
      .any_grant (any_grant)
   );

   assign req_ready = grant;

   // Idle cycles feed zeros so the adder's discarded output stays quiet.
   always_comb begin
      add_a   = FX_ZERO;
      add_b   = FX_ZERO;
      add_sub = 1'b0;
      if (any_grant) begin
         add_a   = req_a[win*W +: W];
         add_b   = req_b[win*W +: W];
         add_sub = req_sub[win];
      end
   end

   fixed_adder u_add (
      .clk (clk),
      .a   (add_a),
      .b   (add_b),
      .sub (add_sub),
      .sum (add_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_reg <= '0;
         resp_id_reg    <= '0;
      end else begin
         resp_valid_reg <= grant;
         if (any_grant) begin
            resp_id_reg <= win;
         end
      end
   end

   assign resp_valid = resp_valid_reg;
   assign resp_id    = resp_id_reg;
   assign resp_sum   = add_sum;

`ifdef FADD_ARB_STATS_EN
   logic [15:0] stall_cnt_reg;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
      logic [15:0] grant_cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            grant_cnt_reg <= '0;
         end else if (grant[gi] && grant_cnt_reg != 16'hFFFF) begin
            grant_cnt_reg <= grant_cnt_reg + 16'd1;
         end
      end
      assign stat_grant_cnt[gi*16 +: 16] = grant_cnt_reg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
      end else if ((|(req_valid & ~req_ready)) && stall_cnt_reg != 16'hFFFF) begin
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end

   assign stat_stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_fadd_share_arbiter.sv
// Scoreboard bench for fadd_share_arbiter: stimulus pushes expected responses, a monitor checks them.
module tb_fadd_share_arbiter;
   localparam int N  = 4;
   localparam int W  = 17;
   localparam int IW = 2;

   typedef struct {
      int              due;
      logic [IW-1:0]   id;
      logic [W-1:0]    sum;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            en;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*W-1:0]  req_a;
   logic [N*W-1:0]  req_b;
   logic [N-1:0]    req_sub;
   logic [N-1:0]    resp_valid;
   logic [W-1:0]    resp_sum;
   logic [IW-1:0]   resp_id;
`ifdef FADD_ARB_STATS_EN
   logic [N*16-1:0] stat_grant_cnt;
   logic [15:0]     stat_stall_cnt;
`endif

   int       errors = 0;
   int       checks = 0;
   int       cyc    = 0;
   bit       run    = 0;
   exp_t     q [$];
   exp_t     mon_x;
   logic [W-1:0] exp_sum [N];

   fadd_share_arbiter #(.N_REQ(N), .W(W), .ID_W(IW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_sub    (req_sub),
      .resp_valid (resp_valid),
      .resp_sum   (resp_sum),
      .resp_id    (resp_id)
`ifdef FADD_ARB_STATS_EN
      ,
      .stat_grant_cnt (stat_grant_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: each cycle either the due response or silence on resp_valid.
   always @(negedge clk) begin
      if (run) begin
         checks++;
         if (q.size() > 0 && q[0].due == cyc) begin
            mon_x = q.pop_front();
            if (resp_valid !== (4'b0001 << mon_x.id) || resp_id !== mon_x.id || resp_sum !== mon_x.sum) begin
               errors++;
               $display("FAIL resp cyc=%0d got valid=%b id=%0d sum=%h exp valid=%b id=%0d sum=%h",
                        cyc, resp_valid, resp_id, resp_sum, 4'b0001 << mon_x.id, mon_x.id, mon_x.sum);
            end else begin
               $display("resp cyc=%0d id=%0d sum=%h", cyc, resp_id, resp_sum);
            end
         end else if (resp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL idle_resp cyc=%0d got valid=%b exp valid=0000", cyc, resp_valid);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end else begin
         $display("check %s cyc=%0d value=%h", name, cyc, got);
      end
   endtask

   task automatic step(input logic [N-1:0] v, input logic e, input logic [N-1:0] exp_rdy, input bit push);
      exp_t x;
      @(posedge clk);
      #1;
      req_valid = v;
      en        = e;
      #1;
      check("ready", 32'(req_ready), 32'(exp_rdy));
      if (push && exp_rdy != '0) begin
         for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) begin
               x.due = cyc + 1;
               x.id  = IW'(i);
               x.sum = exp_sum[i];
               q.push_back(x);
            end
         end
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      en        = 1'b1;
      #1;
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
      req_valid = '0;
      rst_n     = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      req_valid = '0;
      // req0: 6+4=10, req1: 1-0.5=0.5, req2: -6-4=-10, req3: 2+(-3)=-1
      req_a   = {17'h00200, 17'h10600, 17'h00100, 17'h00600};
      req_b   = {17'h10300, 17'h00400, 17'h00080, 17'h00400};
      req_sub = 4'b0110;
      exp_sum[0] = 17'h00A00;
      exp_sum[1] = 17'h00080;
      exp_sum[2] = 17'h10A00;
      exp_sum[3] = 17'h10100;

      repeat (2) @(posedge clk);
      #2;
      check("reset_ready", 32'(req_ready), 32'h0);
      check("reset_resp_valid", 32'(resp_valid), 32'h0);
      check("reset_resp_id", 32'(resp_id), 32'h0);
      req_valid = 4'b1111;
      en        = 1'b1;
      #1;
      check("reset_ready_held", 32'(req_ready), 32'h0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      run   = 1;

      // Single request, then idle.
      step(4'b0001, 1'b1, 4'b0001, 1);
      step(4'b0000, 1'b1, 4'b0000, 1);

      // Round-robin with all valid, pointer starts at 1.
      step(4'b1111, 1'b1, 4'b0010, 1);
      step(4'b1111, 1'b1, 4'b0100, 1);
      step(4'b1111, 1'b1, 4'b1000, 1);
      step(4'b1111, 1'b1, 4'b0001, 1);
      step(4'b1111, 1'b1, 4'b0010, 1);
      step(4'b1111, 1'b1, 4'b0100, 1);
      step(4'b1111, 1'b1, 4'b1000, 1);
      step(4'b1111, 1'b1, 4'b0001, 1);

      // Wrap and idle: req3 alone, idle, req0 alone, idle.
      step(4'b1000, 1'b1, 4'b1000, 1);
      step(4'b0000, 1'b1, 4'b0000, 1);
      step(4'b0001, 1'b1, 4'b0001, 1);
      step(4'b0000, 1'b1, 4'b0000, 1);

      // en gating: one grant, three gated cycles, pointer unchanged after.
      step(4'b1111, 1'b1, 4'b0010, 1);
      step(4'b1111, 1'b0, 4'b0000, 1);
      step(4'b1111, 1'b0, 4'b0000, 1);
      step(4'b1111, 1'b0, 4'b0000, 1);
      step(4'b1111, 1'b1, 4'b0100, 1);
      step(4'b0000, 1'b1, 4'b0000, 1);

      // Single requester valid every cycle: back-to-back results.
      step(4'b0100, 1'b1, 4'b0100, 1);
      step(4'b0100, 1'b1, 4'b0100, 1);
      step(4'b0100, 1'b1, 4'b0100, 1);

      // Reset mid-flight: this op is dropped, then first grant goes to req0.
      step(4'b0100, 1'b1, 4'b0100, 0);
      pulse_reset();
      step(4'b1111, 1'b1, 4'b0001, 1);
      step(4'b0000, 1'b1, 4'b0000, 1);

      // Two requesters continuously valid for 10 cycles from a fresh reset.
      pulse_reset();
      for (int i = 0; i < 10; i++) begin
         step(4'b0011, 1'b1, (i % 2 == 0) ? 4'b0001 : 4'b0010, 1);
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      #1;
`ifdef FADD_ARB_STATS_EN
      check("stat_grant0", 32'(stat_grant_cnt[15:0]), 32'd5);
      check("stat_grant1", 32'(stat_grant_cnt[31:16]), 32'd5);
      check("stat_grant2", 32'(stat_grant_cnt[47:32]), 32'd0);
      check("stat_stall", 32'(stat_stall_cnt), 32'd10);
`endif
      step(4'b0000, 1'b1, 4'b0000, 1);
      step(4'b0000, 1'b1, 4'b0000, 1);
      @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      run = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
